// File: rtl/vend_payout_sequencer_pkg.sv
// Shared types for the vend payout sequencer: change codes, payout FSM states
// and the buffered event format.
package vend_pkg;

  localparam logic [1:0] CHG_NONE = 2'b00;
  localparam logic [1:0] CHG_5    = 2'b01;
  localparam logic [1:0] CHG_10   = 2'b10;
  localparam logic [1:0] CHG_ILL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MOTOR_REQ,
    ST_MOTOR_WAIT,
    ST_COIN_REQ,
    ST_COIN_WAIT,
    ST_GAP,
    ST_FAULT
  } pay_state_t;

  typedef struct packed {
    logic       bottle;
    logic [1:0] coins;
  } vend_evt_t;

  // Number of 5rs coins owed for a change code; the illegal code pays nothing.
  function automatic logic [1:0] coins_for(input logic [1:0] chg);
    case (chg)
      CHG_5:           return 2'd1;
      CHG_10:          return 2'd2;
      CHG_NONE, CHG_ILL: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_payout_sequencer_if.sv
// Handshake bundle between the vending FSM / payout hardware (master) and the
// payout sequencer (slave).
interface vend_payout_sequencer_if;

  logic        vend_valid;
  logic        vend_bottle;
  logic [1:0]  vend_change;
  logic        vend_ready;
  logic        motor_start;
  logic        motor_done;
  logic        coin_eject;
  logic        coin_sensed;
  logic        fault_clr;
  logic        fault;
  logic        err_illegal;
  logic        busy;
  logic [15:0] bottle_cnt;
  logic [15:0] coin_cnt;

  modport master (
    output vend_valid, vend_bottle, vend_change, motor_done, coin_sensed, fault_clr,
    input  vend_ready, motor_start, coin_eject, fault, err_illegal, busy,
           bottle_cnt, coin_cnt
  );

  modport slave (
    input  vend_valid, vend_bottle, vend_change, motor_done, coin_sensed, fault_clr,
    output vend_ready, motor_start, coin_eject, fault, err_illegal, busy,
           bottle_cnt, coin_cnt
  );

endinterface

// File: rtl/vend_evt_fifo.sv
// Synchronous event FIFO (power-of-two DEPTH) with flush; head entry is
// visible on o_data whenever o_empty is low.
module vend_evt_fifo
  import vend_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_push,
  input  vend_evt_t i_data,
  input  logic      i_pop,
  input  logic      i_flush,
  output vend_evt_t o_data,
  output logic      o_full,
  output logic      o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  vend_evt_t     r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full && !i_flush;
  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  assign o_data    = r_mem[r_rd_ptr];

  // NOTE: storage is deliberately not reset; pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/vend_payout_sequencer.sv
// Buffers vend events and plays them out one at a time on the bottle motor and
// coin hopper, with timeout supervision, sticky fault and lifetime counters.
module vend_payout_sequencer
  import vend_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1000,
  parameter int GAP_CYC = 8
) (
  input logic                    clk,
  input logic                    rst,
  vend_payout_sequencer_if.slave bus
);

  localparam int TMAX = (TIMEOUT > GAP_CYC) ? TIMEOUT : GAP_CYC;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYC - 1);

  pay_state_t    r_state;
  logic [1:0]    r_coins_left;
  logic [TW-1:0] r_timer;
  logic          r_motor_start;
  logic          r_coin_eject;
  logic          r_fault;
  logic          r_err_illegal;
  logic [15:0]   r_bottle_cnt;
  logic [15:0]   r_coin_cnt;

  logic      w_ready;
  logic      w_accept;
  logic      w_push;
  logic      w_pop;
  logic      w_flush;
  logic      w_full;
  logic      w_empty;
  vend_evt_t w_push_evt;
  vend_evt_t w_head;

  assign w_ready    = !rst && !w_full && !r_fault;
  assign w_accept   = bus.vend_valid && w_ready;
  assign w_push_evt = '{bottle: bus.vend_bottle, coins: coins_for(bus.vend_change)};
  // Events that would dispense nothing (including illegal change with no bottle) never occupy a slot.
  assign w_push     = w_accept && (w_push_evt.bottle || (w_push_evt.coins != 2'd0));
  assign w_pop      = (r_state == ST_IDLE) && !w_empty;
  assign w_flush    = (r_state == ST_FAULT) && bus.fault_clr;

  vend_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_evt),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_coins_left  <= '0;
      r_timer       <= '0;
      r_motor_start <= 1'b0;
      r_coin_eject  <= 1'b0;
      r_fault       <= 1'b0;
      r_err_illegal <= 1'b0;
      r_bottle_cnt  <= '0;
      r_coin_cnt    <= '0;
    end else begin
      // Pulses are raised only on the edge entering their REQ state.
      r_motor_start <= 1'b0;
      r_coin_eject  <= 1'b0;
      r_err_illegal <= w_accept && (bus.vend_change == CHG_ILL);
      case (r_state)
        ST_IDLE: if (!w_empty) begin
          r_coins_left <= w_head.coins;
          if (w_head.bottle) begin
            r_state       <= ST_MOTOR_REQ;
            r_motor_start <= 1'b1;
          end else begin
            r_state      <= ST_COIN_REQ;
            r_coin_eject <= 1'b1;
          end
        end
        ST_MOTOR_REQ: begin
          r_timer <= '0;
          r_state <= ST_MOTOR_WAIT;
        end
        ST_MOTOR_WAIT: if (bus.motor_done) begin
          r_bottle_cnt <= r_bottle_cnt + 16'd1;
          if (r_coins_left != 2'd0) begin
            r_state      <= ST_COIN_REQ;
            r_coin_eject <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end else if (r_timer == TO_LAST) begin
          r_state <= ST_FAULT;
          r_fault <= 1'b1;
        end else begin
          r_timer <= r_timer + 1'b1;
        end
        ST_COIN_REQ: begin
          r_timer <= '0;
          r_state <= ST_COIN_WAIT;
        end
        ST_COIN_WAIT: if (bus.coin_sensed) begin
          r_coin_cnt   <= r_coin_cnt + 16'd1;
          r_coins_left <= r_coins_left - 2'd1;
          r_timer      <= '0;
          r_state      <= (r_coins_left > 2'd1) ? ST_GAP : ST_IDLE;
        end else if (r_timer == TO_LAST) begin
          r_state <= ST_FAULT;
          r_fault <= 1'b1;
        end else begin
          r_timer <= r_timer + 1'b1;
        end
        ST_GAP: if (r_timer == GAP_LAST) begin
          r_state      <= ST_COIN_REQ;
          r_coin_eject <= 1'b1;
        end else begin
          r_timer <= r_timer + 1'b1;
        end
        ST_FAULT: if (bus.fault_clr) begin
          r_state <= ST_IDLE;
          r_fault <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.vend_ready  = w_ready;
  assign bus.motor_start = r_motor_start;
  assign bus.coin_eject  = r_coin_eject;
  assign bus.fault       = r_fault;
  assign bus.err_illegal = r_err_illegal;
  assign bus.busy        = (r_state != ST_IDLE) || !w_empty;
  assign bus.bottle_cnt  = r_bottle_cnt;
  assign bus.coin_cnt    = r_coin_cnt;

endmodule

// File: tb/tb_vend_payout_sequencer.sv
// Directed plus randomized bench for vend_payout_sequencer; expected payout
// order and counts come from expanding each accepted event into pulses.
module tb_vend_payout_sequencer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 1000;
  localparam int GAP_CYC = 8;

  logic clk = 1'b0;
  logic rst;

  vend_payout_sequencer_if bus ();

  vend_payout_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .GAP_CYC(GAP_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed pulse log: 0 = motor_start, 1 = coin_eject.
  bit log_kind[$];
  int log_cyc[$];
  int n_illegal = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.motor_start) begin log_kind.push_back(1'b0); log_cyc.push_back(cyc); end
      if (bus.coin_eject)  begin log_kind.push_back(1'b1); log_cyc.push_back(cyc); end
      if (bus.err_illegal) n_illegal++;
    end
  end

  // Reference model: each event expands into its ordered list of pulses.
  bit exp_kind[$];
  int exp_bottles = 0;
  int exp_coins   = 0;
  int exp_illegal = 0;
  int n_served    = 0;
  int resp_cyc[int];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_add(input logic b, input logic [1:0] chg);
    int nc;
    nc = (chg == 2'b01) ? 1 : (chg == 2'b10) ? 2 : 0;
    if (chg == 2'b11) exp_illegal++;
    if (b) begin exp_kind.push_back(1'b0); exp_bottles++; end
    for (int i = 0; i < nc; i++) begin exp_kind.push_back(1'b1); exp_coins++; end
  endtask

  // Offers one event and returns at the negedge just after the accepting edge.
  task automatic push_evt(input logic b, input logic [1:0] chg);
    int budget;
    budget = 3000;
    bus.vend_valid = 1'b1; bus.vend_bottle = b; bus.vend_change = chg;
    while (!bus.vend_ready && budget > 0) begin tick(); budget--; end
    tick();
    bus.vend_valid = 1'b0; bus.vend_bottle = 1'b0; bus.vend_change = 2'b00;
    check("push_accepted", 32'(budget > 0), 1);
  endtask

  // Answers every logged pulse after a random delay until the block is idle.
  task automatic serve_all(input string tag);
    int budget;
    budget = 4000;
    while ((n_served < log_kind.size() || bus.busy) && budget > 0) begin
      if (n_served < log_kind.size()) begin
        repeat ($urandom_range(1, 4)) tick();
        if (log_kind[n_served]) bus.coin_sensed = 1'b1; else bus.motor_done = 1'b1;
        resp_cyc[n_served] = cyc;
        n_served++;
        tick();
        bus.coin_sensed = 1'b0; bus.motor_done = 1'b0;
      end else begin
        tick();
      end
      budget--;
    end
    check({tag, "_drain"}, 32'(budget > 0), 1);
  endtask

  task automatic check_log(input string tag);
    check({tag, "_len"}, log_kind.size(), exp_kind.size());
    for (int i = 0; i < exp_kind.size(); i++)
      if (i < log_kind.size()) check($sformatf("%s_kind%0d", tag, i), 32'(log_kind[i]), 32'(exp_kind[i]));
    check({tag, "_bottle_cnt"}, bus.bottle_cnt, 32'(exp_bottles[15:0]));
    check({tag, "_coin_cnt"}, bus.coin_cnt, 32'(exp_coins[15:0]));
  endtask

  task automatic wait_pulse(input string tag, input bit coin, output int at);
    int budget;
    budget = 50;
    while (!(coin ? bus.coin_eject : bus.motor_start) && budget > 0) begin tick(); budget--; end
    check(tag, 32'(coin ? bus.coin_eject : bus.motor_start), 1);
    at = cyc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    int idx;
    int ls;
    bit b3[5];
    logic [1:0] c3[5];
    logic rb;
    logic [1:0] rc;

    rst = 1'b1;
    bus.vend_valid = 1'b0; bus.vend_bottle = 1'b0; bus.vend_change = 2'b00;
    bus.motor_done = 1'b0; bus.coin_sensed = 1'b0; bus.fault_clr = 1'b0;
    repeat (3) tick();
    check("rst_ready_low", bus.vend_ready, 0);
    rst = 1'b0;
    tick();
    check("rst_ready_high", bus.vend_ready, 1);
    check("rst_pulses", {bus.motor_start, bus.coin_eject, bus.fault, bus.err_illegal, bus.busy}, 0);
    check("rst_cnts", {bus.bottle_cnt, bus.coin_cnt}, 0);

    // Latency: accept in cycle 0, motor_start in cycle 2, then one coin.
    bus.vend_valid = 1'b1; bus.vend_bottle = 1'b1; bus.vend_change = 2'b01;
    tick();
    bus.vend_valid = 1'b0; bus.vend_bottle = 1'b0; bus.vend_change = 2'b00;
    model_add(1'b1, 2'b01);
    check("lat_c1_motor", bus.motor_start, 0);
    tick();
    check("lat_c2_motor", bus.motor_start, 1);
    tick();
    bus.motor_done = 1'b1; resp_cyc[n_served] = cyc; n_served++;
    tick();
    bus.motor_done = 1'b0;
    check("lat_bottle_cnt", bus.bottle_cnt, 1);
    check("lat_coin_eject", bus.coin_eject, 1);
    tick();
    bus.coin_sensed = 1'b1; resp_cyc[n_served] = cyc; n_served++;
    tick();
    bus.coin_sensed = 1'b0;
    check("lat_coin_cnt", bus.coin_cnt, 1);
    check("lat_idle", bus.busy, 0);
    check_log("t1");

    // 10rs change only: two ejects spaced by the gap, no motor.
    push_evt(1'b0, 2'b10);
    model_add(1'b0, 2'b10);
    serve_all("t2");
    check_log("t2");
    ls = log_cyc.size();
    if (ls >= 2) check("t2_gap", 32'((log_cyc[ls-1] - log_cyc[ls-2]) >= GAP_CYC + 1), 1);

    // Five events with no responses: DEPTH queued plus one in flight.
    b3 = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    c3 = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b10};
    idx = log_kind.size();
    for (int i = 0; i < 5; i++) begin
      push_evt(b3[i], c3[i]);
      model_add(b3[i], c3[i]);
      check($sformatf("t3_ready%0d", i), bus.vend_ready, (i == 4) ? 0 : 1);
    end
    check("t3_busy", bus.busy, 1);
    check("t3_one_in_flight", log_kind.size(), idx + 1);
    serve_all("t3");
    check_log("t3");
    if (log_kind.size() > idx + 1) check("t3_back_to_back", log_cyc[idx+1] - resp_cyc[idx], 2);
    check("t3_ready_after", bus.vend_ready, 1);

    // Done exactly on the last allowed wait cycle still succeeds.
    push_evt(1'b1, 2'b00);
    model_add(1'b1, 2'b00);
    wait_pulse("tb_motor_seen", 1'b0, c);
    repeat (TIMEOUT) tick();
    check("tb_no_fault_yet", bus.fault, 0);
    bus.motor_done = 1'b1; resp_cyc[n_served] = cyc; n_served++;
    tick();
    bus.motor_done = 1'b0;
    check("tb_fault", bus.fault, 0);
    check("tb_busy", bus.busy, 0);
    check_log("tb");

    // Timeout: fault, FIFO retained, then cleared and flushed.
    push_evt(1'b1, 2'b00);
    wait_pulse("to_motor_seen", 1'b0, c);
    exp_kind.push_back(1'b0);
    push_evt(1'b1, 2'b01);
    ls = 0;
    while (!bus.fault && ls < TIMEOUT + 20) begin tick(); ls++; end
    check("to_latency", cyc - c, TIMEOUT + 1);
    check("to_ready", bus.vend_ready, 0);
    check("to_busy", bus.busy, 1);
    ls = log_kind.size();
    repeat (5) tick();
    check("to_no_pulses", log_kind.size(), ls);
    check("to_fault_sticky", bus.fault, 1);
    bus.fault_clr = 1'b1;
    tick();
    bus.fault_clr = 1'b0;
    check("clr_fault", bus.fault, 0);
    check("clr_busy", bus.busy, 0);
    check("clr_ready", bus.vend_ready, 1);
    n_served = log_kind.size();
    push_evt(1'b1, 2'b01);
    model_add(1'b1, 2'b01);
    serve_all("clr");
    check_log("clr");

    // Illegal change code, stray responses and stray fault_clr in IDLE.
    push_evt(1'b0, 2'b11);
    model_add(1'b0, 2'b11);
    check("ill_pulse", bus.err_illegal, 1);
    tick();
    check("ill_pulse_end", bus.err_illegal, 0);
    check("ill_busy", bus.busy, 0);
    bus.coin_sensed = 1'b1; bus.motor_done = 1'b1; bus.fault_clr = 1'b1;
    tick();
    bus.coin_sensed = 1'b0; bus.motor_done = 1'b0; bus.fault_clr = 1'b0;
    repeat (3) tick();
    check("stray_fault", bus.fault, 0);
    check_log("stray");
    push_evt(1'b1, 2'b11);
    model_add(1'b1, 2'b11);
    check("ill_b_pulse", bus.err_illegal, 1);
    serve_all("ill_b");
    check_log("ill_b");

    // Reset while a coin is outstanding with a second event queued.
    push_evt(1'b0, 2'b01);
    push_evt(1'b1, 2'b00);
    wait_pulse("rs_coin_seen", 1'b1, c);
    exp_kind.push_back(1'b1);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check("rs_pulses", {bus.motor_start, bus.coin_eject, bus.fault, bus.err_illegal, bus.busy}, 0);
    check("rs_cnts", {bus.bottle_cnt, bus.coin_cnt}, 0);
    check("rs_ready", bus.vend_ready, 0);
    rst = 1'b0;
    tick();
    check("rs_ready_after", bus.vend_ready, 1);
    repeat (4) tick();
    check("rs_fifo_empty", bus.busy, 0);
    exp_bottles = 0;
    exp_coins   = 0;
    n_served    = log_kind.size();
    check_log("rs");

    // Randomized batches, each small enough to fit the queue plus one in flight.
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < int'($urandom_range(1, 5)); j++) begin
        rb = 1'($urandom_range(0, 1));
        rc = 2'($urandom_range(0, 3));
        push_evt(rb, rc);
        model_add(rb, rc);
      end
      serve_all($sformatf("rnd%0d", k));
      check_log($sformatf("rnd%0d", k));
    end
    check("illegal_count", n_illegal, exp_illegal);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
